// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter: programmable step, wrap or saturate,
// clamped parallel load, and registered overflow/underflow event pulses.
module updown_mod_counter #(
    parameter int WIDTH    = 5,
    parameter int MODULUS  = 2**WIDTH,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic             UP,
    input  logic [WIDTH-1:0] STEP,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] COUNT,
    output logic             OVF,
    output logic             UNF,
    output logic             AT_MAX,
    output logic             AT_ZERO
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    // Sum is one bit wider so the modulus compare sees the true carry.
    assign sum = {1'b0, COUNT} + {1'b0, STEP};

    always_comb begin
        count_nxt = COUNT;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        if (CLEAR) begin
            count_nxt = '0;
        end else if (LOAD) begin
            count_nxt = ({1'b0, DATA} < MOD_W) ? DATA : MAX_C;
        end else if (ENABLE) begin
            if (UP) begin
                if (sum < MOD_W) begin
                    count_nxt = sum[WIDTH-1:0];
                end else begin
                    ovf_nxt = 1'b1;
                    // Wrapped result is below MODULUS, so WIDTH-bit arithmetic is exact.
                    count_nxt = SATURATE ? MAX_C : (sum[WIDTH-1:0] - MOD_W[WIDTH-1:0]);
                end
            end else begin
                if (STEP <= COUNT) begin
                    count_nxt = COUNT - STEP;
                end else begin
                    unf_nxt   = 1'b1;
                    count_nxt = SATURATE ? '0 : (COUNT + MOD_W[WIDTH-1:0] - STEP);
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            COUNT <= '0;
            OVF   <= 1'b0;
            UNF   <= 1'b0;
        end else begin
            COUNT <= count_nxt;
            OVF   <= ovf_nxt;
            UNF   <= unf_nxt;
        end
    end

    assign AT_MAX  = (COUNT == MAX_C);
    assign AT_ZERO = (COUNT == '0);

    // Simulation-only guards: unknown controls and out-of-range steps.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            assert (!$isunknown({CLEAR, ENABLE, LOAD, UP}))
                else $error("updown_mod_counter: X on control input");
            if (ENABLE && !LOAD && !CLEAR) begin
                assert (!$isunknown(STEP) && ({1'b0, STEP} < MOD_W))
                    else $error("updown_mod_counter: STEP out of range");
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: three counter configurations share stimulus and are
// compared against directed sequences and an arithmetic reference model.
module tb_updown_mod_counter;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       clear = 1'b0;
    logic       en    = 1'b0;
    logic       load  = 1'b0;
    logic       up    = 1'b1;
    logic [4:0] step  = 5'd0;
    logic [4:0] data  = 5'd0;

    logic [3:0] cnt_a, cnt_b;
    logic [4:0] cnt_c;
    logic       ovf_a, unf_a, max_a, zero_a;
    logic       ovf_b, unf_b, max_b, zero_b;
    logic       ovf_c, unf_c, max_c, zero_c;

    int total = 0;
    int bad   = 0;

    // Reference model state, one slot per instance: a wrap/10, b sat/10, c legacy/32.
    int mc [3];
    bit mo [3];
    bit mu [3];
    int mods [3] = '{10, 10, 32};
    bit sats [3] = '{1'b0, 1'b1, 1'b0};

    logic [4:0] oc [3];
    logic       oo [3], ou [3], omax [3], ozero [3];

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
        .CLOCK(clk), .RESET(rst), .CLEAR(clear), .ENABLE(en), .LOAD(load), .UP(up),
        .STEP(step[3:0]), .DATA(data[3:0]), .COUNT(cnt_a), .OVF(ovf_a), .UNF(unf_a),
        .AT_MAX(max_a), .AT_ZERO(zero_a));

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
        .CLOCK(clk), .RESET(rst), .CLEAR(clear), .ENABLE(en), .LOAD(load), .UP(up),
        .STEP(step[3:0]), .DATA(data[3:0]), .COUNT(cnt_b), .OVF(ovf_b), .UNF(unf_b),
        .AT_MAX(max_b), .AT_ZERO(zero_b));

    updown_mod_counter #(.WIDTH(5)) dut_c (
        .CLOCK(clk), .RESET(rst), .CLEAR(clear), .ENABLE(en), .LOAD(load), .UP(up),
        .STEP(step), .DATA(data), .COUNT(cnt_c), .OVF(ovf_c), .UNF(unf_c),
        .AT_MAX(max_c), .AT_ZERO(zero_c));

    assign oc[0] = {1'b0, cnt_a};
    assign oc[1] = {1'b0, cnt_b};
    assign oc[2] = cnt_c;
    assign oo[0] = ovf_a;  assign oo[1] = ovf_b;  assign oo[2] = ovf_c;
    assign ou[0] = unf_a;  assign ou[1] = unf_b;  assign ou[2] = unf_c;
    assign omax[0] = max_a;  assign omax[1] = max_b;  assign omax[2] = max_c;
    assign ozero[0] = zero_a; assign ozero[1] = zero_b; assign ozero[2] = zero_c;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mo[i] = 1'b0; mu[i] = 1'b0;
        end
    endtask

    // One rising edge: advance the model from the inputs in force, then settle.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            int d, s, m;
            d = (i < 2) ? int'(data[3:0]) : int'(data);
            s = (i < 2) ? int'(step[3:0]) : int'(step);
            m = mods[i];
            mo[i] = 1'b0; mu[i] = 1'b0;
            if (clear) mc[i] = 0;
            else if (load) mc[i] = (d < m) ? d : m - 1;
            else if (en && up) begin
                if (mc[i] + s >= m) begin
                    mo[i] = 1'b1;
                    mc[i] = sats[i] ? m - 1 : mc[i] + s - m;
                end else mc[i] = mc[i] + s;
            end else if (en) begin
                if (mc[i] - s < 0) begin
                    mu[i] = 1'b1;
                    mc[i] = sats[i] ? 0 : mc[i] - s + m;
                end else mc[i] = mc[i] - s;
            end
        end
        #1;
    endtask

    task automatic set_ctl(input bit c, input bit e, input bit l, input bit u,
                           input int s, input int d);
        clear = c; en = e; load = l; up = u;
        step = 5'(s); data = 5'(d);
    endtask

    task automatic test_reset();
        set_ctl(0, 0, 0, 1, 0, 0);
        rst = 1'b0;
        model_reset();
        #12;
        total++;
        if (cnt_a !== 4'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
            bad++; $display("FAIL reset_initial: count=%0d ovf=%b unf=%b want 0/0/0", cnt_a, ovf_a, unf_a);
        end
        @(negedge clk); rst = 1'b1;
        set_ctl(0, 0, 1, 1, 0, 7);
        tick();
        total++;
        if (cnt_a !== 4'd7) begin
            bad++; $display("FAIL reset_preload: count=%0d want 7", cnt_a);
        end
        set_ctl(0, 1, 0, 1, 1, 0);
        #2; rst = 1'b0; model_reset(); #1;
        total++;
        if (cnt_a !== 4'd0 || ovf_a !== 1'b0 || unf_a !== 1'b0 || zero_a !== 1'b1) begin
            bad++; $display("FAIL reset_async: count=%0d ovf=%b unf=%b zero=%b want 0/0/0/1",
                            cnt_a, ovf_a, unf_a, zero_a);
        end
        @(negedge clk); rst = 1'b1;
        set_ctl(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_wrap_up();
        int exp_c [4] = '{1, 4, 7, 0};
        bit exp_o [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        set_ctl(0, 0, 1, 1, 0, 8); tick();
        set_ctl(0, 1, 0, 1, 3, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (cnt_a !== 4'(exp_c[k]) || ovf_a !== exp_o[k] || unf_a !== 1'b0) begin
                bad++; $display("FAIL wrap_up[%0d]: count=%0d ovf=%b unf=%b want %0d/%b/0",
                                k, cnt_a, ovf_a, unf_a, exp_c[k], exp_o[k]);
            end
        end
    endtask

    task automatic test_wrap_down();
        int exp_c [3] = '{8, 4, 0};
        bit exp_u [3] = '{1'b1, 1'b0, 1'b0};
        set_ctl(0, 0, 1, 0, 0, 2); tick();
        set_ctl(0, 1, 0, 0, 4, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (cnt_a !== 4'(exp_c[k]) || unf_a !== exp_u[k] || ovf_a !== 1'b0) begin
                bad++; $display("FAIL wrap_down[%0d]: count=%0d unf=%b ovf=%b want %0d/%b/0",
                                k, cnt_a, unf_a, ovf_a, exp_c[k], exp_u[k]);
            end
        end
        total++;
        if (zero_a !== 1'b1) begin
            bad++; $display("FAIL wrap_down_zero: at_zero=%b want 1", zero_a);
        end
    endtask

    task automatic test_saturate();
        set_ctl(0, 0, 1, 1, 0, 7); tick();
        set_ctl(0, 1, 0, 1, 5, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (cnt_b !== 4'd9 || ovf_b !== 1'b1 || max_b !== 1'b1) begin
                bad++; $display("FAIL sat_up[%0d]: count=%0d ovf=%b at_max=%b want 9/1/1",
                                k, cnt_b, ovf_b, max_b);
            end
        end
        set_ctl(0, 0, 1, 0, 0, 3); tick();
        set_ctl(0, 1, 0, 0, 5, 0); tick();
        total++;
        if (cnt_b !== 4'd0 || unf_b !== 1'b1 || ovf_b !== 1'b0) begin
            bad++; $display("FAIL sat_down: count=%0d unf=%b ovf=%b want 0/1/0", cnt_b, unf_b, ovf_b);
        end
        set_ctl(0, 1, 0, 1, 0, 0); tick();
        total++;
        if (cnt_b !== 4'd0 || unf_b !== 1'b0 || ovf_b !== 1'b0) begin
            bad++; $display("FAIL step_zero: count=%0d unf=%b ovf=%b want 0/0/0", cnt_b, unf_b, ovf_b);
        end
    endtask

    task automatic test_load();
        set_ctl(0, 0, 1, 1, 0, 6); tick();
        total++;
        if (cnt_a !== 4'd6) begin
            bad++; $display("FAIL load_plain: count=%0d want 6", cnt_a);
        end
        set_ctl(0, 0, 1, 1, 0, 13); tick();
        total++;
        if (cnt_a !== 4'd9 || max_a !== 1'b1) begin
            bad++; $display("FAIL load_clamp: count=%0d at_max=%b want 9/1", cnt_a, max_a);
        end
        set_ctl(1, 1, 1, 1, 1, 5); tick();
        total++;
        if (cnt_a !== 4'd0 || cnt_c !== 5'd0) begin
            bad++; $display("FAIL clear_over_load: a=%0d c=%0d want 0/0", cnt_a, cnt_c);
        end
        set_ctl(0, 0, 1, 1, 0, 5); tick();
        set_ctl(0, 0, 0, 1, 3, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (cnt_a !== 4'd5 || ovf_a !== 1'b0 || unf_a !== 1'b0) begin
                bad++; $display("FAIL hold[%0d]: count=%0d ovf=%b unf=%b want 5/0/0",
                                k, cnt_a, ovf_a, unf_a);
            end
        end
    endtask

    task automatic test_legacy();
        set_ctl(1, 0, 0, 1, 0, 0); tick();
        set_ctl(0, 1, 0, 1, 1, 0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            total++;
            if (cnt_c !== 5'(k % 32) || ovf_c !== (k == 32)) begin
                bad++; $display("FAIL legacy_count[%0d]: count=%0d ovf=%b want %0d/%b",
                                k, cnt_c, ovf_c, k % 32, (k == 32));
            end
        end
        set_ctl(0, 1, 1, 1, 1, 17); tick();
        total++;
        if (cnt_c !== 5'd17) begin
            bad++; $display("FAIL legacy_load_en: count=%0d want 17", cnt_c);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_ctl($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9), $urandom_range(0, 31));
            tick();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (oc[i] !== 5'(mc[i]) || oo[i] !== mo[i] || ou[i] !== mu[i] ||
                    omax[i] !== (mc[i] == mods[i] - 1) || ozero[i] !== (mc[i] == 0)) begin
                    bad++; $display("FAIL random[%0d] inst%0d: count=%0d ovf=%b unf=%b max=%b zero=%b want %0d/%b/%b",
                                    n, i, oc[i], oo[i], ou[i], omax[i], ozero[i], mc[i], mo[i], mu[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_load();
        test_legacy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
